// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory stage.
//   OP_LOAD / OP_STORE : opcodes that access memory; every other opcode
//                        passes the ALU result straight to writeback.
//   state_t            : stage FSM states (IDLE, ACCESS, RESP).
//   TIMEOUT_CYCLES     : number of ACCESS cycles allowed without mem_ack
//                        when MEM_STAGE_TIMEOUT_EN is defined.
package mem_stage_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b11000;
  localparam logic [4:0] OP_STORE = 5'b11001;

  localparam int unsigned TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundle of all handshake and bus signals around mem_stage.
//   in_*   : execute -> mem_stage instruction handshake
//   mem_*  : mem_stage <-> data memory request/response
//   out_*  : mem_stage -> writeback handshake
//   err    : access timeout pulse (constant 0 unless MEM_STAGE_TIMEOUT_EN)
// Modports:
//   master : the mem_stage side (drives in_ready, mem_req/we/addr/wdata,
//            out_valid/data/rd/wb_en, err)
//   slave  : the surrounding pipeline / memory / testbench side
interface mem_stage_if #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4
);

  logic                      in_valid;
  logic                      in_ready;
  logic [4:0]                in_opcode;
  logic [DATA_WIDTH-1:0]     in_result;
  logic [DATA_WIDTH-1:0]     in_store_data;
  logic [REG_ADDR_WIDTH-1:0] in_rd;

  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_ack;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_wb_en;

  logic                      err;

  modport master (
    input  in_valid, in_opcode, in_result, in_store_data, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output out_valid, out_data, out_rd, out_wb_en,
    input  out_ready,
    output err
  );

  modport slave (
    output in_valid, in_opcode, in_result, in_store_data, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  out_valid, out_data, out_rd, out_wb_en,
    output out_ready,
    input  err
  );

endinterface

// File: rtl/mem_stage_watchdog.sv
// mem_watchdog: 8-bit cycle counter for the ACCESS state timeout.
//   clk, rst   : clock, asynchronous active-high reset
//   i_enable   : FSM is in ACCESS this cycle
//   i_clear    : FSM is outside ACCESS; counter returns to 0
//   o_expired  : this is the TIMEOUT_CYCLES-th consecutive ACCESS cycle
// Only instantiated when MEM_STAGE_TIMEOUT_EN is defined.
module mem_watchdog
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // r_count holds the number of ACCESS cycles already completed, so the
  // edge that ends the last allowed cycle is where the count reaches 255.
  assign o_expired = i_enable && (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage between execute and writeback.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mem_stage_if.master -- instruction input handshake, data memory
//         request/response, writeback output handshake and err pulse.
// LOAD (5'b11000) / STORE (5'b11001) go through IDLE -> ACCESS -> RESP;
// every other opcode is forwarded to writeback with one cycle latency.
// ADDR_WIDTH must not exceed DATA_WIDTH (address is the low ALU bits).
// Optional feature macro: MEM_STAGE_TIMEOUT_EN -- abandons an access after
// 255 cycles without mem_ack and pulses err; otherwise err is tied low.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.master bus
);

  state_t                    r_state;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic                      r_is_load;
  logic                      r_out_valid;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [REG_ADDR_WIDTH-1:0] r_out_rd;
  logic                      r_out_wb_en;

  logic w_in_ready;
  logic w_fire;
  logic w_is_load;
  logic w_is_store;

  assign w_is_load  = (bus.in_opcode == OP_LOAD);
  assign w_is_store = (bus.in_opcode == OP_STORE);
  // A pending result may drain on the same edge a new one is accepted.
  assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_fire     = bus.in_valid && w_in_ready;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic r_err;
  logic w_expired;

  mem_watchdog u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (r_state == ACCESS),
    .i_clear   (r_state != ACCESS),
    .o_expired (w_expired)
  );

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_is_load   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_wb_en <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_fire) begin
            r_out_rd <= bus.in_rd;
            if (w_is_load || w_is_store) begin
              r_mem_addr  <= bus.in_result[ADDR_WIDTH-1:0];
              r_mem_wdata <= bus.in_store_data;
              r_mem_we    <= w_is_store;
              r_is_load   <= w_is_load;
              r_mem_req   <= 1'b1;
              r_state     <= ACCESS;
            end else begin
              r_out_data  <= bus.in_result;
              r_out_wb_en <= 1'b1;
              r_out_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= r_is_load ? bus.mem_rdata : '0;
            r_out_wb_en <= r_is_load;
            r_state     <= RESP;
          end
`ifdef MEM_STAGE_TIMEOUT_EN
          else if (w_expired) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_out_data  <= '0;
            r_out_wb_en <= 1'b0;
            r_state     <= RESP;
          end
`endif
        end
        RESP: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_rd    = r_out_rd;
  assign bus.out_wb_en = r_out_wb_en;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (default 16/16/4 widths).
// Pass-through vectors come from a table; LOAD, STORE, backpressure,
// reset-during-access and (with MEM_STAGE_TIMEOUT_EN) timeout are
// hand-written sequences.
module tb_mem_stage;

  localparam logic [4:0] OPC_LOAD  = 5'b11000;
  localparam logic [4:0] OPC_STORE = 5'b11001;

  logic clk;
  logic rst;

  mem_stage_if #(
    .DATA_WIDTH     (16),
    .ADDR_WIDTH     (16),
    .REG_ADDR_WIDTH (4)
  ) bus ();

  mem_stage #(
    .DATA_WIDTH     (16),
    .ADDR_WIDTH     (16),
    .REG_ADDR_WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid      = 1'b0;
    bus.in_opcode     = 5'd0;
    bus.in_result     = 16'h0000;
    bus.in_store_data = 16'h0000;
    bus.in_rd         = 4'd0;
  endtask

  task automatic drive_instr(input logic [4:0] op, input logic [15:0] res,
                             input logic [15:0] sd, input logic [3:0] rd);
    bus.in_valid      = 1'b1;
    bus.in_opcode     = op;
    bus.in_result     = res;
    bus.in_store_data = sd;
    bus.in_rd         = rd;
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [15:0] result;
    logic [3:0]  rd;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [3:0]  exp_rd;
  } pt_vec_t;

  pt_vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned n_req;

    vecs[0] = '{1'b1, 5'b00000, 16'h1234, 4'd3,  1'b1, 16'h1234, 4'd3};
    vecs[1] = '{1'b1, 5'b10111, 16'hFFFF, 4'd15, 1'b1, 16'hFFFF, 4'd15};
    vecs[2] = '{1'b1, 5'b11010, 16'h8000, 4'd0,  1'b1, 16'h8000, 4'd0};
    vecs[3] = '{1'b1, 5'b11011, 16'h0001, 4'd1,  1'b1, 16'h0001, 4'd1};
    vecs[4] = '{1'b1, 5'b11111, 16'h7FFF, 4'd8,  1'b1, 16'h7FFF, 4'd8};
    vecs[5] = '{1'b1, 5'b01100, 16'hA5A5, 4'd12, 1'b1, 16'hA5A5, 4'd12};
    vecs[6] = '{1'b0, 5'b00000, 16'h0000, 4'd0,  1'b0, 16'hA5A5, 4'd12};

    // ---------------- reset ----------------
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    drive_idle();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_rd",    32'(bus.out_rd),    32'd0);
    chk("rst_out_wb_en", 32'(bus.out_wb_en), 32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ---------------- pass-through table, back to back ----------------
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].valid) drive_instr(vecs[i].op, vecs[i].result, 16'h0000, vecs[i].rd);
      else drive_idle();
      #1;
      chk($sformatf("pt%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      chk($sformatf("pt%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("pt%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].exp_data));
      chk($sformatf("pt%0d_out_rd", i),    32'(bus.out_rd),    32'(vecs[i].exp_rd));
      if (vecs[i].exp_valid) chk($sformatf("pt%0d_wb_en", i), 32'(bus.out_wb_en), 32'd1);
      chk($sformatf("pt%0d_mem_req", i), 32'(bus.mem_req), 32'd0);
    end
    drive_idle();

    // ---------------- ack outside ACCESS is ignored ----------------
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_out_valid", 32'(bus.out_valid), 32'd0);
    chk("stray_ack_mem_req",   32'(bus.mem_req),   32'd0);
    chk("stray_ack_in_ready",  32'(bus.in_ready),  32'd1);

    // ---------------- LOAD with ack on the 3rd request cycle ----------------
    drive_instr(OPC_LOAD, 16'h0040, 16'h0000, 4'd5);
    tick();
    drive_idle();
    n_req = 0;
    for (int c = 1; c <= 3; c++) begin
      if (bus.mem_req) n_req++;
      chk($sformatf("ld_c%0d_addr", c), 32'(bus.mem_addr), 32'h0040);
      chk($sformatf("ld_c%0d_we", c),   32'(bus.mem_we),   32'd0);
      chk($sformatf("ld_c%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("ld_c%0d_out_valid", c), 32'(bus.out_valid), 32'd0);
      if (c == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
      end
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    chk("ld_req_cycles", n_req, 32'd3);
    chk("ld_req_drop",   32'(bus.mem_req),   32'd0);
    chk("ld_out_valid",  32'(bus.out_valid), 32'd1);
    chk("ld_out_data",   32'(bus.out_data),  32'hBEEF);
    chk("ld_out_rd",     32'(bus.out_rd),    32'd5);
    chk("ld_wb_en",      32'(bus.out_wb_en), 32'd1);
    chk("ld_resp_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("ld_done_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ld_done_in_ready",  32'(bus.in_ready),  32'd1);

    // ---------------- STORE with immediate ack ----------------
    drive_instr(OPC_STORE, 16'h0010, 16'h00AA, 4'd7);
    tick();
    drive_idle();
    chk("st_mem_req",   32'(bus.mem_req),   32'd1);
    chk("st_mem_we",    32'(bus.mem_we),    32'd1);
    chk("st_mem_addr",  32'(bus.mem_addr),  32'h0010);
    chk("st_mem_wdata", 32'(bus.mem_wdata), 32'h00AA);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ack = 1'b0;
    chk("st_req_drop",  32'(bus.mem_req),   32'd0);
    chk("st_out_valid", 32'(bus.out_valid), 32'd1);
    chk("st_wb_en",     32'(bus.out_wb_en), 32'd0);
    chk("st_out_data",  32'(bus.out_data),  32'h0000);
    tick();
    chk("st_done_out_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- backpressure then back-to-back ----------------
    bus.out_ready = 1'b0;
    drive_instr(5'b00001, 16'h5A5A, 16'h0000, 4'd9);
    tick();
    drive_instr(5'b00010, 16'h6B6B, 16'h0000, 4'd10);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_out_data", c),  32'(bus.out_data),  32'h5A5A);
      chk($sformatf("bp%0d_out_rd", c),    32'(bus.out_rd),    32'd9);
      chk($sformatf("bp%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive_idle();
    chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_out_data",  32'(bus.out_data),  32'h6B6B);
    chk("b2b_out_rd",    32'(bus.out_rd),    32'd10);
    tick();
    chk("b2b_drain_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- reset in 2nd request cycle ----------------
    drive_instr(OPC_LOAD, 16'h0080, 16'h0000, 4'd4);
    tick();
    drive_idle();
    chk("rs_c1_mem_req", 32'(bus.mem_req), 32'd1);
    tick();
    chk("rs_c2_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_async_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rs_async_out_valid", 32'(bus.out_valid), 32'd0);
    #2;
    rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hCAFE;
    n_req = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.out_valid || bus.mem_req) n_req++;
    end
    bus.mem_ack = 1'b0;
    chk("rs_no_output_cycles", n_req, 32'd0);
    drive_instr(5'b00011, 16'h4321, 16'h0000, 4'd6);
    #1;
    chk("rs_next_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive_idle();
    chk("rs_next_out_valid", 32'(bus.out_valid), 32'd1);
    chk("rs_next_out_data",  32'(bus.out_data),  32'h4321);
    chk("rs_next_out_rd",    32'(bus.out_rd),    32'd6);
    tick();

`ifdef MEM_STAGE_TIMEOUT_EN
    // ---------------- timeout: LOAD with no ack ----------------
    drive_instr(OPC_LOAD, 16'h0100, 16'h0000, 4'd2);
    tick();
    drive_idle();
    n_req = 0;
    while (bus.mem_req && n_req < 300) begin
      n_req++;
      if (bus.err) chk("to_early_err", 32'(bus.err), 32'd0);
      tick();
    end
    chk("to_req_cycles", n_req, 32'd255);
    chk("to_err",        32'(bus.err),       32'd1);
    chk("to_out_valid",  32'(bus.out_valid), 32'd1);
    chk("to_wb_en",      32'(bus.out_wb_en), 32'd0);
    chk("to_out_data",   32'(bus.out_data),  32'h0000);
    tick();
    chk("to_err_pulse",  32'(bus.err),       32'd0);
`else
    chk("err_tied_low", 32'(bus.err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
